// File: rtl/vdisk_pkg.sv
// Shared definitions for the virtual-drive SD transfer arbiter.
//   NUM_DEV       : number of virtual drives behind hps_io
//   DEV_*         : drive index constants
//   vdisk_state_t : transfer sequencer states
package vdisk_pkg;

  localparam int NUM_DEV = 3;

  localparam int DEV_HDD = 0;
  localparam int DEV_FD1 = 1;
  localparam int DEV_FD2 = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    XFER  = 2'd2,
    DONE  = 2'd3
  } vdisk_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
//   pend : pending mask, one bit per drive
//   last : index of the most recently completed grant
//   vld  : some drive is pending
//   idx  : first pending drive searching from last+1, wrapping
module rr_arbiter #(
  parameter int NUM_DEV = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_DEV-1:0] pend,
  input  logic [IDX_W-1:0]   last,
  output logic               vld,
  output logic [IDX_W-1:0]   idx
);

  always_comb begin
    vld = 1'b0;
    idx = '0;
    for (int k = 1; k <= NUM_DEV; k++) begin
      if (!vld && pend[(int'(last) + k) % NUM_DEV]) begin
        vld = 1'b1;
        idx = IDX_W'((int'(last) + k) % NUM_DEV);
      end
    end
  end

endmodule

// File: rtl/vdisk_sd_arbiter.sv
// Serialises SD block transfers from the virtual drives onto hps_io.
// Only one transfer is in flight because the sd_buff_* bus is shared.
//   clk_sys, reset_n        : clock, async active-low reset
//   req_rd/req_wr/req_lba   : per-drive request pulses and LBA
//   dev_busy/done/err       : per-drive status back to the clients
//   grant                   : one-hot selected drive (sd_buff_din mux)
//   sd_lba/sd_rd/sd_wr/ack  : hps_io SD lanes
//   cpu_wait                : stalls the CPU while the hard disk is busy
module vdisk_sd_arbiter
  import vdisk_pkg::*;
#(
  parameter int NUM_DEV   = vdisk_pkg::NUM_DEV,
  parameter int TIMEOUT_W = 20
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic [NUM_DEV-1:0]      req_rd,
  input  logic [NUM_DEV-1:0]      req_wr,
  input  logic [NUM_DEV-1:0][31:0] req_lba,
  output logic [NUM_DEV-1:0]      dev_busy,
  output logic [NUM_DEV-1:0]      dev_done,
  output logic [NUM_DEV-1:0]      dev_err,
  output logic [NUM_DEV-1:0]      grant,
  output logic [31:0]             sd_lba,
  output logic [NUM_DEV-1:0]      sd_rd,
  output logic [NUM_DEV-1:0]      sd_wr,
  input  logic [NUM_DEV-1:0]      sd_ack,
  output logic                    cpu_wait
);

  localparam int IDX_W = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
  // Fires on the (2^TIMEOUT_W-1)th ISSUE cycle without an ack.
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  vdisk_state_t          state, state_d;
  logic [IDX_W-1:0]      sel, sel_d, last_grant, last_d, arb_idx;
  logic                  arb_vld;
  logic [TIMEOUT_W-1:0]  cnt, cnt_d;
  logic [NUM_DEV-1:0]    pend_rd, pend_wr, clr_rd, clr_wr, old_ack;
  logic [NUM_DEV-1:0]    grant_d, rd_d, wr_d, done_d, err_d;
  logic [31:0]           lba_d;
  logic                  ack_rise, ack_fall, cpu_wait_d;

  rr_arbiter #(.NUM_DEV(NUM_DEV), .IDX_W(IDX_W)) u_rr (
    .pend (pend_rd | pend_wr),
    .last (last_grant),
    .vld  (arb_vld),
    .idx  (arb_idx)
  );

  // Only the granted drive's ack is looked at.
  assign ack_rise = sd_ack[sel] & ~old_ack[sel];
  assign ack_fall = ~sd_ack[sel] & old_ack[sel];

  assign dev_busy = pend_rd | pend_wr | grant;

  always_comb begin
    state_d = state;
    sel_d   = sel;
    last_d  = last_grant;
    cnt_d   = cnt;
    grant_d = grant;
    lba_d   = sd_lba;
    rd_d    = sd_rd;
    wr_d    = sd_wr;
    done_d  = '0;
    err_d   = '0;
    clr_rd  = '0;
    clr_wr  = '0;
    unique case (state)
      IDLE: begin
        // grant is held one cycle past dev_done so the client still owns
        // the buffer mux while it sees completion; release it here first.
        if (|grant) begin
          grant_d = '0;
        end else if (arb_vld) begin
          sel_d            = arb_idx;
          grant_d          = '0;
          grant_d[arb_idx] = 1'b1;
          lba_d            = req_lba[arb_idx];
          cnt_d            = '0;
          state_d          = ISSUE;
          // Write wins when both are pending; the read stays queued.
          if (pend_wr[arb_idx]) begin
            wr_d[arb_idx]   = 1'b1;
            clr_wr[arb_idx] = 1'b1;
          end else begin
            rd_d[arb_idx]   = 1'b1;
            clr_rd[arb_idx] = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (ack_rise) begin
          rd_d    = '0;
          wr_d    = '0;
          state_d = XFER;
        end else if (cnt == TMO_LAST) begin
          rd_d       = '0;
          wr_d       = '0;
          err_d[sel] = 1'b1;
          grant_d    = '0;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt + TIMEOUT_W'(1);
        end
      end
      XFER: begin
        if (ack_fall) state_d = DONE;
      end
      DONE: begin
        done_d[sel] = 1'b1;
        last_d      = sel;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Uses the next grant so cpu_wait drops on the same edge as grant[0].
    cpu_wait_d = pend_rd[DEV_HDD] | pend_wr[DEV_HDD] | grant_d[DEV_HDD];
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sel        <= '0;
      last_grant <= IDX_W'(NUM_DEV - 1);
      cnt        <= '0;
      pend_rd    <= '0;
      pend_wr    <= '0;
      old_ack    <= '0;
      grant      <= '0;
      sd_lba     <= '0;
      sd_rd      <= '0;
      sd_wr      <= '0;
      dev_done   <= '0;
      dev_err    <= '0;
      cpu_wait   <= 1'b0;
    end else begin
      sel        <= sel_d;
      last_grant <= last_d;
      cnt        <= cnt_d;
      // A new pulse on the serviced drive re-arms pending: never merged.
      pend_rd    <= (pend_rd & ~clr_rd) | req_rd;
      pend_wr    <= (pend_wr & ~clr_wr) | req_wr;
      old_ack    <= sd_ack;
      grant      <= grant_d;
      sd_lba     <= lba_d;
      sd_rd      <= rd_d;
      sd_wr      <= wr_d;
      dev_done   <= done_d;
      dev_err    <= err_d;
      cpu_wait   <= cpu_wait_d;
    end
  end

endmodule

// File: tb/tb_vdisk_sd_arbiter.sv
module tb_vdisk_sd_arbiter;

  logic             clk_sys = 1'b0;
  logic             reset_n = 1'b0;
  logic [2:0]       req_rd  = '0;
  logic [2:0]       req_wr  = '0;
  logic [2:0][31:0] req_lba = '0;
  logic [2:0]       sd_ack  = '0;
  logic [2:0]       dev_busy, dev_done, dev_err, grant, sd_rd, sd_wr;
  logic [31:0]      sd_lba;
  logic             cpu_wait;

  int n_chk  = 0;
  int n_fail = 0;

  logic mon_cw   = 1'b0;
  int   cw_drops = 0;
  int   n_done0  = 0;

  vdisk_sd_arbiter #(.NUM_DEV(3), .TIMEOUT_W(4)) dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .req_rd   (req_rd),
    .req_wr   (req_wr),
    .req_lba  (req_lba),
    .dev_busy (dev_busy),
    .dev_done (dev_done),
    .dev_err  (dev_err),
    .grant    (grant),
    .sd_lba   (sd_lba),
    .sd_rd    (sd_rd),
    .sd_wr    (sd_wr),
    .sd_ack   (sd_ack),
    .cpu_wait (cpu_wait)
  );

  always #5 clk_sys = ~clk_sys;

  // Watches cpu_wait across two back-to-back drive-0 transactions.
  always @(negedge clk_sys) begin
    if (mon_cw) begin
      if (!cpu_wait && n_done0 < 2) cw_drops++;
      if (dev_done[0]) n_done0++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic pulse(input logic [2:0] rd, input logic [2:0] wr);
    req_rd = rd;
    req_wr = wr;
    tick();
    req_rd = '0;
    req_wr = '0;
  endtask

  // Waits for the issue, checks it, acks 5 cycles later, checks completion.
  task automatic run_xfer(input int dev, input logic [31:0] lba, input bit is_wr,
                          input logic [2:0] inj, output int wait_cyc, output logic cw_k1);
    logic [2:0] one;
    one      = '0;
    one[dev] = 1'b1;
    wait_cyc = 0;
    while ((sd_rd | sd_wr) == 3'b000 && wait_cyc < 40) begin
      tick();
      wait_cyc++;
    end
    chk("grant", grant, one);
    chk("sd_lba", sd_lba, lba);
    chk("sd_rd", sd_rd, is_wr ? 3'b000 : one);
    chk("sd_wr", sd_wr, is_wr ? one : 3'b000);
    repeat (4) tick();
    sd_ack[dev] = 1'b1;
    tick();
    chk("strobe_drop", sd_rd | sd_wr, 0);
    chk("grant_xfer", grant, one);
    req_rd = inj;
    tick();
    req_rd      = '0;
    sd_ack[dev] = 1'b0;
    tick();
    chk("done_early", dev_done, 0);
    tick();
    chk("done_pulse", dev_done, one);
    chk("grant_k1", grant, one);
    cw_k1 = cpu_wait;
    tick();
    chk("done_clear", dev_done, 0);
    chk("grant_rel", grant, 0);
  endtask

  initial begin
    int   w, n;
    logic cw;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   w, n;
    logic cw;
    req_lba[0] = 32'h0000_1234;
    req_lba[1] = 32'h0000_BEEF;
    req_lba[2] = 32'h00C0_FFEE;

    // Reset state
    repeat (3) tick();
    chk("reset_outs", {dev_busy, dev_done, dev_err, grant, sd_rd, sd_wr, sd_lba, cpu_wait}, 0);
    reset_n = 1'b1;
    tick();

    // HDD read
    pulse(3'b001, 3'b000);
    chk("hdd_busy_n", dev_busy, 3'b001);
    chk("hdd_rd_n", sd_rd, 0);
    chk("hdd_cw_n", cpu_wait, 0);
    tick();
    chk("hdd_cw_n1", cpu_wait, 1);
    run_xfer(0, 32'h1234, 1'b0, 3'b000, w, cw);
    chk("hdd_wait", w, 0);
    chk("hdd_cw_k1", cw, 1);
    chk("hdd_cw_fall", cpu_wait, 0);
    chk("hdd_busy_end", dev_busy, 0);

    // Round robin 0,1,2 back to back (last_grant = 0 here, so reset drive 0
    // would be last; prime last_grant = 2 first via drive 2)
    pulse(3'b100, 3'b000);
    run_xfer(2, 32'h00C0_FFEE, 1'b0, 3'b000, w, cw);
    pulse(3'b111, 3'b000);
    run_xfer(0, 32'h1234, 1'b0, 3'b000, w, cw);
    run_xfer(1, 32'hBEEF, 1'b0, 3'b000, w, cw);
    chk("rr_b2b_1", w, 1);
    run_xfer(2, 32'h00C0_FFEE, 1'b0, 3'b000, w, cw);
    chk("rr_b2b_2", w, 1);

    // last_grant = 0, drives 0 and 2 pending -> 2 before 0
    pulse(3'b001, 3'b000);
    run_xfer(0, 32'h1234, 1'b0, 3'b000, w, cw);
    pulse(3'b101, 3'b000);
    run_xfer(2, 32'h00C0_FFEE, 1'b0, 3'b000, w, cw);
    run_xfer(0, 32'h1234, 1'b0, 3'b000, w, cw);

    // Write and read on drive 1 in the same cycle: write first
    pulse(3'b010, 3'b010);
    run_xfer(1, 32'hBEEF, 1'b1, 3'b000, w, cw);
    chk("wr_rd_pend", dev_busy, 3'b010);
    run_xfer(1, 32'hBEEF, 1'b0, 3'b000, w, cw);
    chk("wr_rd_idle", dev_busy, 0);

    // Timeout: last_grant = 1, drives 0 and 2 pending -> 2 first, never acked
    pulse(3'b101, 3'b000);
    w = 0;
    while (sd_rd == 3'b000 && w < 40) begin
      tick();
      w++;
    end
    chk("to_grant", grant, 3'b100);
    n = 0;
    while (sd_rd[2] && n < 40) begin
      n++;
      tick();
    end
    chk("to_len", n, 15);
    chk("to_err", dev_err, 3'b100);
    chk("to_rd", sd_rd, 0);
    chk("to_grant_clr", grant, 0);
    chk("to_busy", dev_busy, 3'b001);
    tick();
    chk("to_err_clr", dev_err, 0);
    chk("to_next", grant, 3'b001);
    run_xfer(0, 32'h1234, 1'b0, 3'b000, w, cw);

    // Reset during XFER
    pulse(3'b010, 3'b000);
    w = 0;
    while (sd_rd == 3'b000 && w < 40) begin
      tick();
      w++;
    end
    chk("rst_issue", sd_rd, 3'b010);
    sd_ack[1] = 1'b1;
    tick();
    chk("rst_in_xfer", {sd_rd, grant}, {3'b000, 3'b010});
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async", {dev_busy, dev_done, dev_err, grant, sd_rd, sd_wr, sd_lba, cpu_wait}, 0);
    sd_ack[1] = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    pulse(3'b111, 3'b000);
    run_xfer(0, 32'h1234, 1'b0, 3'b000, w, cw);
    run_xfer(1, 32'hBEEF, 1'b0, 3'b000, w, cw);
    run_xfer(2, 32'h00C0_FFEE, 1'b0, 3'b000, w, cw);

    // Re-request drive 0 during its XFER: cpu_wait must not drop between
    pulse(3'b001, 3'b000);
    tick();
    mon_cw = 1'b1;
    run_xfer(0, 32'h1234, 1'b0, 3'b001, w, cw);
    chk("rereq_busy", dev_busy, 3'b001);
    run_xfer(0, 32'h1234, 1'b0, 3'b000, w, cw);
    chk("rereq_b2b", w, 1);
    mon_cw = 1'b0;
    chk("cw_continuous", cw_drops, 0);
    chk("cw_done_cnt", n_done0, 2);
    chk("cw_final", cpu_wait, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
